fetch_unit: RTL and testbench

Instruction-fetch and next-PC stage that sits directly upstream of `control_unit` in the RISC-V core. It owns the program counter and fetches each instruction from instruction memory over a req/ack handshake. It holds the instruction and presents its decode fields (`op`, `funct3`, `funct7_5`) until the core retires it. It then uses `control_unit`'s `branch`/`jump` outputs and the datapath `zero` flag to select the next PC.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch and next-PC stage. Owns the PC, fetches over a
//            req/ack handshake, holds the instruction until retire.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        jalr,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        retire,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_trap,
    output logic [31:0] instret
);

    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_exec  = 2'd1;
    localparam logic [1:0] c_st_halt  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic        r_trap;

    logic        w_pc_src;
    logic [31:0] w_next_pc;

    always_comb begin
        w_pc_src = (branch & zero) | jump;
        if (jalr) begin
            w_next_pc = alu_result & 32'hFFFF_FFFE;
        end else if (w_pc_src) begin
            w_next_pc = r_pc + imm_ext;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_fetch;
            r_pc      <= RESET_PC;
            r_instr   <= NOP_INSTR;
            r_instret <= 32'd0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (retire) begin
                        if (w_next_pc[1:0] == 2'b00) begin
                            r_pc      <= w_next_pc;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= c_st_fetch;
                        end else begin
                            // Misaligned target: freeze PC/instret for trap handling
                            r_trap  <= 1'b1;
                            r_instr <= NOP_INSTR;
                            r_state <= c_st_halt;
                        end
                    end
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_instr <= NOP_INSTR;
                    r_state <= c_st_halt;
                end
            endcase
        end
    end

    // Gating with rst keeps req/valid low for every cycle reset is held
    assign imem_req      = (r_state == c_st_fetch) & ~rst;
    assign instr_valid   = (r_state == c_st_exec) & ~rst;
    assign imem_addr     = r_pc;
    assign pc            = r_pc;
    assign pc_plus4      = r_pc + 32'd4;
    assign instr         = r_instr;
    assign op            = r_instr[6:0];
    assign funct3        = r_instr[14:12];
    assign funct7_5      = r_instr[30];
    assign misalign_trap = r_trap;
    assign instret       = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit: vector table, random
//            instruction stream against a next-PC model, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        jalr;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        retire;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_trap;
    logic [31:0] instret;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .branch       (branch),
        .jump         (jump),
        .zero         (zero),
        .jalr         (jalr),
        .imm_ext      (imm_ext),
        .alu_result   (alu_result),
        .retire       (retire),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .op           (op),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_trap(misalign_trap),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_trap;

    typedef struct {
        int          waits;
        int          hold;
        logic        br;
        logic        jp;
        logic        z;
        logic        jr;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_ctrl();
        branch     = 1'($urandom());
        jump       = 1'($urandom());
        zero       = 1'($urandom());
        jalr       = 1'($urandom());
        imm_ext    = $urandom();
        alu_result = $urandom();
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_instret = 32'h0;
        m_trap    = 1'b0;
    endtask

    // One full fetch + exec + retire transaction, checked against the model.
    task automatic run_instr(input int waits, input int hold, input logic br, input logic jp,
                             input logic z, input logic jr, input logic [31:0] imm,
                             input logic [31:0] alu);
        logic [31:0] word;
        logic [63:0] sum;
        logic [31:0] nxt;
        word = $urandom();
        #1;
        check("fetch_req", {31'b0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        check("fetch_valid", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            retire = 1'b1;
            tick();
            retire = 1'b0;
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_rdata = $urandom();
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_req", {31'b0, imem_req}, 32'd0);
        check("exec_instr", instr, word);
        check("exec_op", {25'b0, op}, {25'b0, word[6:0]});
        check("exec_funct3", {29'b0, funct3}, {29'b0, word[14:12]});
        check("exec_funct7_5", {31'b0, funct7_5}, {31'b0, word[30]});
        check("exec_pc", pc, m_pc);
        check("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        for (int i = 0; i < hold; i++) begin
            imem_rdata = $urandom();
            noise_ctrl();
            tick();
            check("hold_instr", instr, word);
            check("hold_fields", {20'b0, funct7_5, funct3, op, 1'b0}, {20'b0, word[30], word[14:12], word[6:0], 1'b0});
            check("hold_pc", pc, m_pc);
            check("hold_valid", {31'b0, instr_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        branch     = br;
        jump       = jp;
        zero       = z;
        jalr       = jr;
        imm_ext    = imm;
        alu_result = alu;
        retire     = 1'b1;
        tick();
        retire = 1'b0;
        noise_ctrl();
        if (jr) begin
            nxt = alu & 32'hFFFF_FFFE;
        end else if ((br && z) || jp) begin
            sum = {32'b0, m_pc} + {32'b0, imm};
            nxt = sum[31:0];
        end else begin
            sum = {32'b0, m_pc} + 64'd4;
            nxt = sum[31:0];
        end
        if (nxt % 4 == 0) begin
            m_pc      = nxt;
            m_instret = m_instret + 32'd1;
        end else begin
            m_trap = 1'b1;
        end
        check("retire_pc", pc, m_pc);
        check("retire_instret", instret, m_instret);
        check("retire_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_instr"}, instr, c_nop);
        check({tag, "_instret"}, instret, 32'h0);
        check({tag, "_trap"}, {31'b0, misalign_trap}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] saved_instret;
        int          sel;

        //            waits hold br jp z  jr imm            alu            exp_pc
        vecs[0]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0004};
        vecs[1]  = '{1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,        32'h0,         32'h0000_0008};
        vecs[2]  = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h7,         32'h0000_000C};
        vecs[3]  = '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8,         32'h0,         32'h0000_0010};
        vecs[4]  = '{0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0008};
        vecs[5]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_000C};
        vecs[6]  = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0010};
        vecs[7]  = '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0014};
        vecs[8]  = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,         32'h0000_0020};
        vecs[9]  = '{0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0120};
        vecs[10] = '{3, 5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0201, 32'h0000_0200};
        vecs[11] = '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h4,         32'h0000_0301, 32'h0000_0300};

        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        retire     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        jalr       = 1'b0;
        imm_ext    = 32'h0;
        alu_result = 32'h0;
        tick();
        tick();
        check_reset_values("reset");
        check("reset_addr", imem_addr, 32'h0);
        model_reset();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].waits, vecs[i].hold, vecs[i].br, vecs[i].jp, vecs[i].z,
                      vecs[i].jr, vecs[i].imm, vecs[i].alu);
            check("vec_pc", pc, vecs[i].exp_pc);
        end
        check("vec_instret", instret, 32'd12);

        // Random instruction stream with aligned targets only
        for (int i = 0; i < 40; i++) begin
            imm = $urandom() & 32'hFFFF_FFFC;
            alu = $urandom() & 32'hFFFF_FFFD;
            sel = int'($urandom_range(0, 3));
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom()), 1'(sel == 1), 1'($urandom()), 1'(sel == 0), imm, alu);
        end

        // PC wrap-around
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFD);
        check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap_pc", pc, 32'h0);

        // Misaligned jump traps and halts
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0040);
        saved_instret = instret;
        run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
        check("trap_flag", {31'b0, misalign_trap}, 32'd1);
        check("trap_pc", pc, 32'h40);
        check("trap_instret", instret, saved_instret);
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            retire     = 1'b1;
            imem_rdata = $urandom();
            jump       = 1'b0;
            jalr       = 1'b0;
            tick();
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
            check("halt_instr", instr, c_nop);
            check("halt_pc", pc, 32'h40);
            check("halt_instret", instret, saved_instret);
            check("halt_trap", {31'b0, misalign_trap}, 32'd1);
        end
        imem_ack = 1'b0;
        retire   = 1'b0;
        rst      = 1'b1;
        tick();
        check_reset_values("halt_rst");
        rst = 1'b0;
        model_reset();

        // Reset mid-fetch with a coincident ack
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check_reset_values("midfetch_rst");
        rst = 1'b0;
        model_reset();
        run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post_rst_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
